// File: rtl/stream_demux_n.sv
// Registered 1:N stream demultiplexer with a one-beat buffer, broadcast delivery
// and a saturating counter for beats addressed to a nonexistent channel.
module stream_demux_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = $clog2(NCH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bcast,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [NCH-1:0]   pending_reg;
    logic [NCH-1:0]   pending_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [CNT_W-1:0] drop_reg;
    logic [CNT_W-1:0] drop_next;

    logic [NCH-1:0]   sel_hit;
    logic [NCH-1:0]   target_mask;
    logic             target_ok;
    logic             last;
    logic             accept;

    // One-hot decode of in_sel; an out-of-range index yields an all-zero vector.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
            assign sel_hit[gi] = (in_sel == SEL_W'(gi));
        end
    endgenerate

    assign target_ok   = in_bcast | (|sel_hit);
    assign target_mask = in_bcast ? {NCH{1'b1}} : sel_hit;

    // The buffer frees up in the same cycle its last pending channel takes the beat.
    assign last     = ((pending_reg & ~out_ready) == '0);
    assign in_ready = last;
    assign accept   = in_valid & last;

    always_comb begin
        pending_next = pending_reg & ~out_ready;
        data_next    = data_reg;
        drop_next    = drop_reg;
        if (accept) begin
            if (target_ok) begin
                pending_next = target_mask;
                data_next    = in_data;
            end else begin
                pending_next = '0;
                if (!(&drop_reg)) begin
                    drop_next = drop_reg + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            data_reg    <= '0;
            drop_reg    <= '0;
        end else begin
            pending_reg <= pending_next;
            data_reg    <= data_next;
            drop_reg    <= drop_next;
        end
    end

    assign out_valid = pending_reg;
    assign out_data  = data_reg;
    assign busy      = |pending_reg;
    assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance for handshake,
// broadcast and streaming, and a 3-channel instance for dropped beats.
module tb_stream_demux_n;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_bcast;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] drop_cnt;

    logic       in_valid3;
    logic       in_ready3;
    logic [7:0] in_data3;
    logic [1:0] in_sel3;
    logic       in_bcast3;
    logic [2:0] out_valid3;
    logic [2:0] out_ready3;
    logic [7:0] out_data3;
    logic       busy3;
    logic [7:0] drop_cnt3;

    int checks;
    int errors;
    int xfer [4];
    int xfer_snap [4];

    stream_demux_n #(.WIDTH(8), .NCH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    stream_demux_n #(.WIDTH(8), .NCH(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .in_sel(in_sel3), .in_bcast(in_bcast3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .busy(busy3), .drop_cnt(drop_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) xfer[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n && out_valid[i] && out_ready[i]) xfer[i] = xfer[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_sel     = 2'd0;
        in_bcast   = 1'b0;
        out_ready  = 4'b0000;
        in_valid3  = 1'b0;
        in_data3   = 8'h00;
        in_sel3    = 2'd0;
        in_bcast3  = 1'b0;
        out_ready3 = 3'b000;

        // 1: reset state and a single beat to channel 2
        #2;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        #20;
        rst_n = 1'b1;
        step();
        check("idle_out_valid", 32'(out_valid), 32'h0);
        check("idle_in_ready", 32'(in_ready), 32'h1);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_drop_cnt", 32'(drop_cnt), 32'h0);
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_sel    = 2'd2;
        out_ready = 4'b1111;
        step();
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'h4);
        check("t1_out_data", 32'(out_data), 32'hA5);
        check("t1_busy", 32'(busy), 32'h1);
        step();
        check("t1_valid_clear", 32'(out_valid), 32'h0);

        // 2: backpressure on channel 1
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        in_sel    = 2'd1;
        out_ready = 4'b1101;
        step();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t2_out_valid_c%0d", c), 32'(out_valid), 32'h2);
            check($sformatf("t2_out_data_c%0d", c), 32'(out_data), 32'h3C);
            check($sformatf("t2_in_ready_c%0d", c), 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 4'b1111;
        #1;
        check("t2_in_ready_drain", 32'(in_ready), 32'h1);
        step();
        check("t2_out_valid_after", 32'(out_valid), 32'h0);

        // 3: broadcast drained in two halves
        for (int i = 0; i < 4; i++) xfer_snap[i] = xfer[i];
        in_valid  = 1'b1;
        in_bcast  = 1'b1;
        in_data   = 8'h77;
        in_sel    = 2'd0;
        out_ready = 4'b0011;
        step();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        check("t3_out_valid_all", 32'(out_valid), 32'hF);
        check("t3_out_data", 32'(out_data), 32'h77);
        check("t3_in_ready_part", 32'(in_ready), 32'h0);
        step();
        check("t3_out_valid_hi", 32'(out_valid), 32'hC);
        out_ready = 4'b1100;
        #1;
        check("t3_in_ready_last", 32'(in_ready), 32'h1);
        step();
        check("t3_out_valid_done", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_xfer_ch%0d", i), 32'(xfer[i] - xfer_snap[i]), 32'h1);
        end

        // 4: back-to-back streaming over all channels
        out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                in_sel   = 2'(k);
                in_data  = 8'(k + 1);
            end else begin
                in_valid = 1'b0;
            end
            if (k > 0) begin
                check($sformatf("t4_out_valid_%0d", k), 32'(out_valid), 32'(1 << (k - 1)));
                check($sformatf("t4_out_data_%0d", k), 32'(out_data), 32'(k));
            end
            check($sformatf("t4_in_ready_%0d", k), 32'(in_ready), 32'h1);
            step();
        end
        check("t4_out_valid_end", 32'(out_valid), 32'h0);

        // 6: reset in the middle of a held beat and with a nonzero drop count
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_sel    = 2'd3;
        out_ready = 4'b0000;
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        in_data3  = 8'h99;
        step();
        in_valid = 1'b0;
        step();
        in_valid3 = 1'b0;
        check("t6_out_valid_pre", 32'(out_valid), 32'h8);
        check("t6_drop3_pre", 32'(drop_cnt3), 32'h2);
        check("t6_out_valid3_pre", 32'(out_valid3), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out_valid_rst", 32'(out_valid), 32'h0);
        check("t6_busy_rst", 32'(busy), 32'h0);
        check("t6_drop3_rst", 32'(drop_cnt3), 32'h0);
        check("t6_in_ready_rst", 32'(in_ready), 32'h1);
        step();
        #3;
        rst_n = 1'b1;
        step();
        check("t6_in_ready_post", 32'(in_ready), 32'h1);
        check("t6_out_valid_post", 32'(out_valid), 32'h0);

        // 5: out-of-range select on the 3-channel instance, then saturation
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        in_data3  = 8'hEE;
        check("t5_in_ready3", 32'(in_ready3), 32'h1);
        step();
        check("t5_drop3_first", 32'(drop_cnt3), 32'h1);
        check("t5_out_valid3_first", 32'(out_valid3), 32'h0);
        for (int n = 1; n < 300; n++) step();
        in_valid3 = 1'b0;
        check("t5_drop3_sat", 32'(drop_cnt3), 32'hFF);
        check("t5_busy3", 32'(busy3), 32'h0);
        check("t5_out_data3_kept", 32'(out_data3), 32'h0);
        in_valid3  = 1'b1;
        in_sel3    = 2'd2;
        in_data3   = 8'h11;
        out_ready3 = 3'b000;
        step();
        in_valid3 = 1'b0;
        check("t5_valid3_ch2", 32'(out_valid3), 32'h4);
        check("t5_data3_ch2", 32'(out_data3), 32'h11);
        check("t5_drop3_hold", 32'(drop_cnt3), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
Registered, parametrised 1:N stream demultiplexer. It succeeds the combinational 1:4 demux with a valid/ready handshake on every port, configurable data width and channel count, a broadcast mode and a saturating counter for dropped beats. It sits between a single producer and N consumer channels, and holds one beat in an internal buffer until every targeted channel has accepted it.

Parameters:
WIDTH, 8, data bits per beat
NCH, 4, number of output channels (2..16)
SEL_W, $clog2(NCH), select width; derived and not overridden
CNT_W, 8, drop-counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  WIDTH  beat payload
in_sel  input  SEL_W  destination channel index
in_bcast  input  1  1 = deliver the beat to all NCH channels; in_sel is ignored
out_valid  output  NCH  per-channel valid, bit i = channel i
out_ready  input  NCH  per-channel ready
out_data  output  WIDTH  buffered payload, shared by all channels
busy  output  1  buffer holds an undelivered beat (pending != 0)
drop_cnt  output  CNT_W  count of beats dropped for an out-of-range in_sel, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Internal state:
  - pending[NCH-1:0]: channels that have not yet taken the buffered beat.
  - data_q[WIDTH-1:0]: the buffered beat.
  - drop_q[CNT_W-1:0]: the drop counter.
- Output mapping: out_valid = pending; out_data = data_q; busy = |pending; drop_cnt = drop_q.
- Reset values: pending = 0, data_q = 0, drop_q = 0. All out_valid bits are 0 and in_ready is 1 while rst_n = 0 and in the first cycle after release.
- Handshake per channel i: a transfer occurs when out_valid[i] & out_ready[i]. Bit i of pending clears at that clock edge. out_valid[i] never drops without a transfer. out_data is stable while any pending bit is set.
- Drain condition: last = ((pending & ~out_ready) == 0), meaning every still-pending channel takes the beat this cycle.
- in_ready = last. This is true when the buffer is empty, and also during the final drain cycle, which gives back-to-back throughput of 1 beat per cycle. in_ready depends combinationally on out_ready; in_valid must not depend on in_ready.
- Accept: an accept occurs when in_valid & in_ready.
  - Target mask = all ones if in_bcast. Otherwise it is one-hot(in_sel) if in_sel < NCH.
  - On accept with a valid target: pending <= mask and data_q <= in_data. The beat appears on out_valid in the next cycle, so latency is 1 cycle.
  - On accept with in_sel >= NCH and in_bcast = 0 (possible only when NCH is not a power of 2): the beat is consumed and dropped. pending becomes 0 (after any drain this cycle), data_q is unchanged, and drop_q increments, saturating at 2^CNT_W-1.
- No accept in the cycle: pending <= pending & ~out_ready.
- Broadcast: the beat stays buffered until every channel has taken it. Channels may take it in different cycles. A channel that has already taken it sees out_valid low for the rest of the beat.
- Simultaneous accept and final drain: the new mask replaces pending, so there is no bubble and no duplicate delivery.
- Reset mid-operation: any buffered beat is discarded immediately (pending = 0) and drop_q is cleared. Reset is not counted as a drop.
- No combinational path from in_data or in_sel to any output.

Test Plan:
1. Reset, then release → out_valid = 4'b0000, in_ready = 1, busy = 0, drop_cnt = 0. Send in_data = 8'hA5, in_sel = 2, with out_ready = 4'b1111 → next cycle out_valid = 4'b0100 and out_data = 8'hA5. Valid clears after one cycle.
2. Backpressure: beat 8'h3C to channel 1, out_ready[1] held low for 5 cycles. Expect out_valid = 4'b0010 and out_data = 8'h3C stable across those cycles, and in_ready = 0. Raise out_ready[1] → in_ready = 1 in that same cycle, and out_valid = 0 the next cycle.
3. Broadcast: in_bcast = 1 with 8'h77. out_ready = 4'b0011 first, then 4'b1100. Expect out_valid = 4'b1111, then 4'b1100, then 4'b0000. Each channel sees exactly one transfer.
4. Streaming: in_valid held high with sel sequence 0,1,2,3 and data 1..4, out_ready all 1 → one beat per cycle, each appearing on the matching channel one cycle later, with no gaps.
5. Drop with NCH = 3: in_sel = 3, in_bcast = 0 → beat accepted, out_valid stays 0, drop_cnt goes 0→1. Repeat 300 times with CNT_W = 8 → drop_cnt saturates at 255.
6. Reset mid-beat: assert rst_n = 0 while out_valid = 4'b1000 and drop_cnt = 2 → out_valid and drop_cnt are 0 immediately, without waiting for a clock edge. After release, in_ready = 1.
